fifo_rd_serializer: RTL
=======================

# fifo_rd_serializer

Downstream drain stage for the show-ahead data FIFO. It pops IN_W-bit words from the FIFO read port and emits them as OUT_W-bit slices on a valid/ready stream, least-significant slice first. Words load back-to-back with no bubble, so a continuously ready sink sustains one slice per cycle.

## Interface
- IN_W, 128: FIFO word width; must equal the FIFO DATA_W.
- OUT_W, 32: output slice width; IN_W must be an integer multiple of OUT_W.
- RATIO, IN_W/OUT_W (derived, not overridden): slices per word; RATIO=1 is legal.

- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- i_en  in  1  drain enable; gates only the loading of new words.
- o_fifo_rden  out  1  FIFO pop strobe; combinational, one cycle per word.
- i_fifo_rddata  in  IN_W  FIFO head word; valid whenever i_fifo_empty=0.
- i_fifo_empty  in  1  FIFO empty flag.
- o_valid  out  1  output slice valid.
- o_data  out  OUT_W  output slice.
- o_last  out  1  high with the final slice (index RATIO-1) of each word.
- i_ready  in  1  sink accepts the slice when o_valid & i_ready.
- o_busy  out  1  a word is held (equals o_valid).

## Operation
- Registers:
  - word_rg[IN_W]: held word.
  - idx_rg: slice index, width max(1,$clog2(RATIO)).
  - state_rg: IDLE or SEND.
- Signals:
  - accept = o_valid & i_ready.
  - last_acc = accept & (idx_rg == RATIO-1).
  - load = rstn & i_en & !i_fifo_empty & (state_rg==IDLE | last_acc).
- o_fifo_rden = load. The pop and the capture of i_fifo_rddata into word_rg happen on the same edge; there is no extra read latency, because the FIFO is show-ahead.
- State transitions:
  - IDLE, load: capture the word, idx_rg<=0, go to SEND.
  - IDLE, no load: stay in IDLE.
  - SEND, accept and idx_rg<RATIO-1: idx_rg<=idx_rg+1.
  - SEND, last_acc and load: capture the next word, idx_rg<=0, stay in SEND (no bubble).
  - SEND, last_acc and no load: go to IDLE.
  - SEND, no accept: hold all state.
- Outputs:
  - o_valid = (state_rg==SEND).
  - o_data = word_rg[idx_rg*OUT_W +: OUT_W].
  - o_last = o_valid & (idx_rg==RATIO-1).
- Stream rules:
  - Once o_valid rises, o_valid and o_data stay stable until accept.
  - Slices are never dropped or duplicated.
- i_en low: the held word still drains completely, and no new pop is issued. Deasserting i_en never truncates a word.
- i_fifo_empty while SEND: no effect until the last slice is accepted; the block then goes to IDLE.
- The block never pops an empty FIFO. load requires !i_fifo_empty, independent of the FIFO's own guard.
- Reset (rstn=0 at an edge):
  - State: state_rg=IDLE, idx_rg=0, word_rg=0.
  - Outputs: o_fifo_rden=0 in the same cycle (gated by rstn).
  - Mid-word reset: the remaining slices of the held word are discarded. That word was already popped and is lost; this is accepted behaviour.

## Timing
- Reset values: o_valid=0, o_last=0, o_data=0, o_busy=0, o_fifo_rden=0.
- Latency: FIFO non-empty with i_en=1 in IDLE during cycle N gives o_fifo_rden=1 in cycle N and o_valid=1 with slice 0 in cycle N+1.
- Throughput with i_ready held at 1 and the FIFO non-empty: one slice per cycle, and one pop every RATIO cycles.
- Pop alignment: o_fifo_rden asserts in the same cycle as the last-slice accept.
- RATIO=1: o_last=1 whenever o_valid=1. Pops may occur every cycle.
- No combinational path exists from i_ready to o_valid or o_data. The only combinational paths are from i_ready, i_fifo_empty and i_en to o_fifo_rden.

## Test plan
- **Reset:** rstn=0 for 3 cycles with the FIFO non-empty and i_en=1 -> o_fifo_rden=0, o_valid=0, o_data=0 throughout.
- **Single word:** IN_W=128, OUT_W=32, word 0x0000000F_0000000E_0000000D_0000000C, i_ready=1 -> one rden pulse, then beats 0xC, 0xD, 0xE, 0xF on consecutive cycles, o_last only on 0xF, then o_valid=0.
- **Back-to-back:** 3 words queued, i_ready=1 -> 12 consecutive valid beats with no gap, rden pulses at cycles 0, 4 and 8, o_last at beats 4, 8 and 12.
- **Backpressure:** i_ready pattern 1,0,0,1,0,1,1,1 repeating -> o_data stable while stalled, output equals the input slice sequence exactly, rden only in last-slice accept cycles.
- **Enable gating:** i_en=0 after slice 1 of word A, word B queued -> A's slices 2 and 3 are delivered and B is not popped; i_en=1 -> B is popped next cycle and delivered.
- **Mid-word reset:** rstn=0 while slice 2 is valid -> o_valid=0 next cycle, A's slices 2 and 3 never appear; after reset, the next FIFO word is delivered from slice 0.

Source files
------------

// File: rtl/fifo_rd_serializer_if.sv
// Drain-side bundle of the FIFO read serializer: FIFO read port plus
// the outgoing slice stream.
interface fifo_rd_serializer_if #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 32
);
  logic             i_en;
  logic             o_fifo_rden;
  logic [IN_W-1:0]  i_fifo_rddata;
  logic             i_fifo_empty;
  logic             o_valid;
  logic [OUT_W-1:0] o_data;
  logic             o_last;
  logic             i_ready;
  logic             o_busy;

  modport master (
    input  i_en,
    output o_fifo_rden,
    input  i_fifo_rddata,
    input  i_fifo_empty,
    output o_valid,
    output o_data,
    output o_last,
    input  i_ready,
    output o_busy
  );

  modport slave (
    output i_en,
    input  o_fifo_rden,
    output i_fifo_rddata,
    output i_fifo_empty,
    input  o_valid,
    input  o_data,
    input  o_last,
    output i_ready,
    input  o_busy
  );
endinterface

// File: rtl/fifo_rd_serializer.sv
// Pops words from a show-ahead FIFO and streams them out as
// OUT_W-bit slices, LS slice first, with no bubble between words.
module fifo_rd_serializer #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  fifo_rd_serializer_if.master bus
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

  logic [IN_W-1:0] word_rg;
  logic [IW-1:0]   idx_rg;
  logic [0:0]      state_rg;

  logic valid;
  logic at_last;
  logic accept;
  logic last_acc;
  logic load;

  assign valid    = (state_rg == SEND);
  assign at_last  = (idx_rg == LAST_IDX);
  assign accept   = valid & bus.i_ready;
  assign last_acc = accept & at_last;

  // Refill either from idle or in the same cycle the last slice leaves.
  assign load = rstn & bus.i_en & ~bus.i_fifo_empty &
                ((state_rg == IDLE) | last_acc);

  assign bus.o_fifo_rden = load;
  assign bus.o_valid     = valid;
  assign bus.o_data      = word_rg[idx_rg*OUT_W +: OUT_W];
  assign bus.o_last      = valid & at_last;
  assign bus.o_busy      = valid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      word_rg  <= '0;
      idx_rg   <= '0;
      state_rg <= IDLE;
    end else if (load) begin
      word_rg  <= bus.i_fifo_rddata;
      idx_rg   <= '0;
      state_rg <= SEND;
    end else if (last_acc) begin
      state_rg <= IDLE;
    end else if (accept) begin
      idx_rg   <= idx_rg + IW'(1);
    end
  end
endmodule
